usiq_nibble_streamer: RTL and testbench

//  Drains 24-bit RX IQ words from the read side of usiq_fifo and presents them as a 4-bit

---
 rtl/usiq_nibble_streamer.sv | 164 ++++++++++++++++
 tb/tb_usiq_nibble_streamer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usiq_nibble_streamer.sv
// Drains 24-bit RX IQ words from the FIFO read side and serves them to the Pi as nibbles, MSB first.
// Also produces a hysteretic samples-available flag and a saturating underrun counter.
module usiq_nibble_streamer #(
   parameter int DW     = 24,
   parameter int NW     = 4,
   parameter int LW     = 11,
   parameter int THR_HI = 256,
   parameter int THR_LO = 64
) (
   input  logic          clk,
   input  logic          rstb,
   input  logic [DW-1:0] s_tdata,
   input  logic          s_tvalid,
   input  logic          s_tlast,
   input  logic [LW-1:0] s_tlength,
   output logic          s_tready,
   input  logic          nib_req,
   output logic [NW-1:0] nib_data,
   output logic          nib_valid,
   output logic          nib_last,
   output logic          samples_avail,
   input  logic          underrun_clr,
   output logic [15:0]   underrun_cnt
);

   localparam int NIB = DW / NW;
   localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [IW-1:0] IDX_LAST = IW'(NIB - 1);
   localparam logic [LW-1:0] THR_HI_L = LW'(THR_HI);
   localparam logic [LW-1:0] THR_LO_L = LW'(THR_LO);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t          state_r, state_s;
   logic [DW-1:0]   shreg_r, shreg_s;
   logic [IW-1:0]   idx_r, idx_s;
   logic            held_last_r, held_last_s;
   logic            last_nib_s;
   logic            pop_s;
   logic            underrun_s;

   assign last_nib_s = (idx_r == IDX_LAST);

   // State register.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic: leave SEND only when the last nibble is taken with nothing queued.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (s_tvalid) state_s = SEND;
            else          state_s = IDLE;
         end
         SEND: begin
            if (nib_req && last_nib_s && !s_tvalid) state_s = IDLE;
            else                                    state_s = SEND;
         end
         default: state_s = IDLE;
      endcase
   end

   // FSM outputs: pop strobe and underrun event; a request during an IDLE pop is ignored.
   always_comb begin
      pop_s      = 1'b0;
      underrun_s = 1'b0;
      case (state_r)
         IDLE: begin
            pop_s      = s_tvalid;
            underrun_s = nib_req && !s_tvalid;
         end
         SEND: begin
            pop_s      = s_tvalid && nib_req && last_nib_s;
            underrun_s = 1'b0;
         end
         default: begin
            pop_s      = 1'b0;
            underrun_s = 1'b0;
         end
      endcase
      // Gated by reset so no sample is popped and lost while the block is held in reset.
      s_tready = pop_s && rstb;
   end

   // Shift-register datapath next values.
   always_comb begin
      shreg_s     = shreg_r;
      idx_s       = idx_r;
      held_last_s = held_last_r;
      if (pop_s) begin
         shreg_s     = s_tdata;
         idx_s       = {IW{1'b0}};
         held_last_s = s_tlast;
      end else if ((state_r == SEND) && nib_req) begin
         if (!last_nib_s) begin
            shreg_s = shreg_r << NW;
            idx_s   = idx_r + {{(IW-1){1'b0}}, 1'b1};
         end else begin
            shreg_s     = {DW{1'b0}};
            idx_s       = {IW{1'b0}};
            held_last_s = 1'b0;
         end
      end else begin
         shreg_s     = shreg_r;
         idx_s       = idx_r;
         held_last_s = held_last_r;
      end
   end

   // Datapath registers and registered nibble outputs.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         shreg_r     <= {DW{1'b0}};
         idx_r       <= {IW{1'b0}};
         held_last_r <= 1'b0;
         nib_data    <= {NW{1'b0}};
         nib_valid   <= 1'b0;
         nib_last    <= 1'b0;
      end else begin
         shreg_r     <= shreg_s;
         idx_r       <= idx_s;
         held_last_r <= held_last_s;
         nib_data    <= shreg_s[DW-1 -: NW];
         nib_valid   <= (state_s == SEND);
         nib_last    <= held_last_s && (idx_s == IDX_LAST);
      end
   end

   // Fill-level flag with hysteresis between THR_LO and THR_HI.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         samples_avail <= 1'b0;
      end else if (s_tlength > THR_HI_L) begin
         samples_avail <= 1'b1;
      end else if (s_tlength <= THR_LO_L) begin
         samples_avail <= 1'b0;
      end else begin
         samples_avail <= samples_avail;
      end
   end

   // Saturating underrun counter; clear wins over a same-cycle increment.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         underrun_cnt <= 16'h0000;
      end else if (underrun_clr) begin
         underrun_cnt <= 16'h0000;
      end else if (underrun_s && (underrun_cnt != 16'hFFFF)) begin
         underrun_cnt <= underrun_cnt + 16'h0001;
      end else begin
         underrun_cnt <= underrun_cnt;
      end
   end

endmodule

// File: tb/tb_usiq_nibble_streamer.sv
// Bench for usiq_nibble_streamer: a queue-based FIFO and nibble-count model predict every output.
module tb_usiq_nibble_streamer;

   localparam int NIB = 6;

   typedef struct packed {
      logic [23:0] data;
      logic        last;
   } smp_t;

   logic        clk = 1'b0;
   logic        rstb = 1'b0;
   logic [23:0] s_tdata = 24'h0;
   logic        s_tvalid = 1'b0;
   logic        s_tlast = 1'b0;
   logic [10:0] s_tlength = 11'd0;
   logic        s_tready;
   logic        nib_req = 1'b0;
   logic [3:0]  nib_data;
   logic        nib_valid;
   logic        nib_last;
   logic        samples_avail;
   logic        underrun_clr = 1'b0;
   logic [15:0] underrun_cnt;

   usiq_nibble_streamer dut (
      .clk(clk), .rstb(rstb), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
      .s_tlength(s_tlength), .s_tready(s_tready), .nib_req(nib_req), .nib_data(nib_data),
      .nib_valid(nib_valid), .nib_last(nib_last), .samples_avail(samples_avail),
      .underrun_clr(underrun_clr), .underrun_cnt(underrun_cnt)
   );

   always #5 clk = ~clk;

   smp_t        fifo_q[$];
   smp_t        m_cur;
   int          m_rem = 0;
   logic [15:0] m_cnt = 16'h0;
   logic        m_avail = 1'b0;

   logic        exp_tready, exp_valid, exp_last;
   logic [3:0]  exp_data;
   logic        obs_tready, obs_valid, obs_last, obs_avail;
   logic [3:0]  obs_data;
   logic [15:0] obs_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // One clock: drive FIFO head and request, advance the model, capture DUT outputs.
   task automatic tick(input logic req, input logic clr);
      logic pop, under;
      @(negedge clk);
      nib_req      = req;
      underrun_clr = clr;
      s_tvalid     = (fifo_q.size() != 0);
      s_tdata      = s_tvalid ? fifo_q[0].data : 24'($urandom);
      s_tlast      = s_tvalid ? fifo_q[0].last : 1'($urandom);
      #1 obs_tready = s_tready;
      pop   = 1'b0;
      under = 1'b0;
      if (m_rem == 0) begin
         if (fifo_q.size() != 0) pop = 1'b1;
         else if (req)           under = 1'b1;
      end else if (req) begin
         m_rem--;
         if (m_rem == 0 && fifo_q.size() != 0) pop = 1'b1;
      end
      if (pop) begin
         m_cur = fifo_q.pop_front();
         m_rem = NIB;
      end
      if (clr) m_cnt = 16'h0;
      else if (under && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'h1;
      if (s_tlength > 11'd256)      m_avail = 1'b1;
      else if (s_tlength <= 11'd64) m_avail = 1'b0;
      exp_tready = pop;
      exp_valid  = (m_rem > 0);
      exp_data   = (m_rem > 0) ? 4'(m_cur.data >> (4 * (m_rem - 1))) : 4'h0;
      exp_last   = (m_rem == 1) && m_cur.last;
      @(posedge clk);
      #1;
      obs_data  = nib_data;
      obs_valid = nib_valid;
      obs_last  = nib_last;
      obs_avail = samples_avail;
      obs_cnt   = underrun_cnt;
   endtask

   task automatic assert_reset();
      @(negedge clk);
      rstb         = 1'b0;
      nib_req      = 1'($urandom);
      underrun_clr = 1'($urandom);
      s_tvalid     = 1'b1;
      s_tdata      = 24'($urandom);
      s_tlast      = 1'($urandom);
      s_tlength    = 11'($urandom);
      m_rem   = 0;
      m_cnt   = 16'h0;
      m_avail = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic release_reset();
      @(negedge clk);
      nib_req      = 1'b0;
      underrun_clr = 1'b0;
      s_tvalid     = 1'b0;
      s_tlength    = 11'd0;
      rstb         = 1'b1;
   endtask

   task automatic test_reset();
      assert_reset();
      n_tests++; if (s_tready !== 1'b0) begin n_fail++; $display("FAIL reset_tready got %b exp 0", s_tready); end
      n_tests++; if (nib_data !== 4'h0) begin n_fail++; $display("FAIL reset_data got %h exp 0", nib_data); end
      n_tests++; if (nib_valid !== 1'b0 || nib_last !== 1'b0) begin n_fail++; $display("FAIL reset_flags got v%b l%b exp 0", nib_valid, nib_last); end
      n_tests++; if (samples_avail !== 1'b0) begin n_fail++; $display("FAIL reset_avail got %b exp 0", samples_avail); end
      n_tests++; if (underrun_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h exp 0", underrun_cnt); end
      release_reset();
      tick(1'b0, 1'b0);
      n_tests++; if (obs_tready !== 1'b0 || obs_valid !== 1'b0) begin n_fail++; $display("FAIL idle_empty got tready %b valid %b exp 0 0", obs_tready, obs_valid); end
   endtask

   task automatic test_single();
      logic [3:0] exp_n [6] = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
      int pops = 0;
      fifo_q.push_back('{data: 24'hABCDEF, last: 1'b1});
      tick(1'b0, 1'b0);
      pops += int'(obs_tready);
      for (int i = 0; i < 6; i++) begin
         n_tests++; if (obs_data !== exp_n[i] || obs_valid !== 1'b1) begin n_fail++; $display("FAIL single_nib%0d got %h/v%b exp %h/v1", i, obs_data, obs_valid, exp_n[i]); end
         n_tests++; if (obs_last !== (i == 5)) begin n_fail++; $display("FAIL single_last%0d got %b exp %b", i, obs_last, (i == 5)); end
         tick(1'b1, 1'b0);
         pops += int'(obs_tready);
         tick(1'b0, 1'b0);
         pops += int'(obs_tready);
      end
      n_tests++; if (obs_valid !== 1'b0 || obs_data !== 4'h0) begin n_fail++; $display("FAIL single_end got v%b d%h exp v0 d0", obs_valid, obs_data); end
      n_tests++; if (pops != 1) begin n_fail++; $display("FAIL single_pops got %0d exp 1", pops); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] seq [12];
      int pop_at [$];
      fifo_q.push_back('{data: 24'h123456, last: 1'b0});
      fifo_q.push_back('{data: 24'h789ABC, last: 1'b1});
      tick(1'b0, 1'b0);
      if (obs_tready) pop_at.push_back(0);
      seq[0] = obs_data;
      for (int k = 1; k <= 12; k++) begin
         tick(1'b1, 1'b0);
         if (obs_tready) pop_at.push_back(k);
         if (k < 12) begin
            seq[k] = obs_data;
            n_tests++; if (obs_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_gap at %0d got valid %b exp 1", k, obs_valid); end
         end
      end
      for (int i = 0; i < 12; i++) begin
         n_tests++; if (seq[i] !== 4'(i + 1)) begin n_fail++; $display("FAIL b2b_nib%0d got %h exp %h", i, seq[i], 4'(i + 1)); end
      end
      n_tests++; if (pop_at.size() != 2) begin n_fail++; $display("FAIL b2b_pops got %0d exp 2", pop_at.size()); end
      else begin
         n_tests++; if (pop_at[1] - pop_at[0] != 6) begin n_fail++; $display("FAIL b2b_spacing got %0d exp 6", pop_at[1] - pop_at[0]); end
      end
      n_tests++; if (obs_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end got valid %b exp 0", obs_valid); end
   endtask

   task automatic test_underrun();
      tick(1'b0, 1'b1);
      repeat (3) tick(1'b1, 1'b0);
      n_tests++; if (obs_cnt !== 16'd3) begin n_fail++; $display("FAIL under3 got %h exp 0003", obs_cnt); end
      n_tests++; if (obs_data !== 4'h0 || obs_valid !== 1'b0) begin n_fail++; $display("FAIL under_data got %h/v%b exp 0/v0", obs_data, obs_valid); end
      tick(1'b0, 1'b1);
      repeat (65534) tick(1'b1, 1'b0);
      n_tests++; if (obs_cnt !== 16'hFFFE) begin n_fail++; $display("FAIL under_fffe got %h exp fffe", obs_cnt); end
      repeat (2) tick(1'b1, 1'b0);
      n_tests++; if (obs_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL under_sat got %h exp ffff", obs_cnt); end
      tick(1'b1, 1'b1);
      n_tests++; if (obs_cnt !== 16'h0) begin n_fail++; $display("FAIL under_clr got %h exp 0", obs_cnt); end
   endtask

   task automatic test_avail();
      logic [10:0] lens [5] = '{11'd256, 11'd257, 11'd100, 11'd65, 11'd64};
      logic        expf [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      s_tlength = 11'd0;
      tick(1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         s_tlength = lens[i];
         tick(1'b0, 1'b0);
         n_tests++; if (obs_avail !== expf[i]) begin n_fail++; $display("FAIL avail_len%0d got %b exp %b", lens[i], obs_avail, expf[i]); end
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 9) < 2 && fifo_q.size() < 8)
            fifo_q.push_back('{data: 24'($urandom), last: 1'($urandom)});
         s_tlength = 11'($urandom_range(0, 400));
         tick(1'($urandom_range(0, 2) != 0), ($urandom_range(0, 49) == 0));
         n_tests++; if (obs_tready !== exp_tready) begin n_fail++; $display("FAIL rnd_tready c%0d got %b exp %b", c, obs_tready, exp_tready); end
         n_tests++; if (obs_valid !== exp_valid) begin n_fail++; $display("FAIL rnd_valid c%0d got %b exp %b", c, obs_valid, exp_valid); end
         n_tests++; if (obs_data !== exp_data) begin n_fail++; $display("FAIL rnd_data c%0d got %h exp %h", c, obs_data, exp_data); end
         n_tests++; if (obs_last !== exp_last) begin n_fail++; $display("FAIL rnd_last c%0d got %b exp %b", c, obs_last, exp_last); end
         n_tests++; if (obs_avail !== m_avail) begin n_fail++; $display("FAIL rnd_avail c%0d got %b exp %b", c, obs_avail, m_avail); end
         n_tests++; if (obs_cnt !== m_cnt) begin n_fail++; $display("FAIL rnd_cnt c%0d got %h exp %h", c, obs_cnt, m_cnt); end
      end
   endtask

   task automatic test_reset_mid();
      fifo_q.delete();
      assert_reset();
      release_reset();
      fifo_q.push_back('{data: 24'h654321, last: 1'b0});
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      tick(1'b1, 1'b0);
      n_tests++; if (obs_data !== 4'h4) begin n_fail++; $display("FAIL mid_pre got %h exp 4", obs_data); end
      fifo_q.push_back('{data: 24'h0FEDCB, last: 1'b1});
      assert_reset();
      n_tests++; if (nib_valid !== 1'b0 || nib_data !== 4'h0 || s_tready !== 1'b0) begin n_fail++; $display("FAIL mid_reset got v%b d%h r%b exp 0", nib_valid, nib_data, s_tready); end
      release_reset();
      tick(1'b0, 1'b0);
      n_tests++; if (obs_tready !== 1'b1 || obs_valid !== 1'b1 || obs_data !== 4'h0) begin n_fail++; $display("FAIL mid_first got r%b v%b d%h exp r1 v1 d0", obs_tready, obs_valid, obs_data); end
      tick(1'b1, 1'b0);
      n_tests++; if (obs_data !== 4'hF) begin n_fail++; $display("FAIL mid_second got %h exp f", obs_data); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_underrun();
      test_avail();
      test_random();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
